// File: rtl/mem_access_pkg.sv
// Shared memory-access encodings for the load-extraction and store paths,
// plus the store buffer entry layout.
package mem_access_pkg;

  localparam int MA_DATA_BITS = 32;
  localparam int MA_ADDR_BITS = 32;

  localparam logic [1:0] SZ_WORD  = 2'd0;
  localparam logic [1:0] SZ_BYTE  = 2'd1;
  localparam logic [1:0] SZ_HALF  = 2'd2;
  localparam logic [1:0] SZ_UNDEF = 2'd3;

  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;

  // Only the word address is kept; the lane is carried by be.
  typedef struct packed {
    logic [MA_ADDR_BITS-3:0] waddr;
    logic [MA_DATA_BITS-1:0] wdata;
    logic [3:0]              be;
  } swb_entry_t;

endpackage

// File: rtl/store_aligner.sv
// Places right-justified store data onto byte lanes and derives byte enables;
// flags widths/offsets that cannot be expressed as a single aligned write.
module store_aligner
  import mem_access_pkg::*;
(
  input  logic [1:0]              addr_lo,
  input  logic [MA_DATA_BITS-1:0] data,
  input  logic [1:0]              store_word,
  output logic [MA_DATA_BITS-1:0] wdata,
  output logic [3:0]              be,
  output logic                    illegal
);

  always_comb begin
    wdata   = data;
    be      = 4'b0000;
    illegal = 1'b0;
    case (store_word)
      SZ_WORD: begin
        wdata   = data;
        be      = BE_ALL;
        illegal = (addr_lo != 2'b00);
      end
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata   = {2{data[15:0]}};
        be      = addr_lo[1] ? BE_HI : BE_LO;
        illegal = addr_lo[0];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns MEM-stage stores, queues them in a small FIFO and
// drains them to data memory over req/ack, flagging loads to pending words.
module store_write_buffer
  import mem_access_pkg::*;
#(
  parameter int DATA_BITS = MA_DATA_BITS,
  parameter int ADDR_BITS = MA_ADDR_BITS,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [ADDR_BITS-1:0] st_addr,
  input  logic [DATA_BITS-1:0] st_data,
  input  logic [1:0]           StoreWord,
  output logic                 misaligned,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic [ADDR_BITS-1:0] ld_addr,
  output logic                 ld_conflict,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [DEPTH-1:0]     entry_valid;
  swb_entry_t           fifo [DEPTH];

  logic [DATA_BITS-1:0] al_wdata;
  logic [3:0]           al_be;
  logic                 al_illegal;
  logic                 accept, push, pop;
  swb_entry_t           head;
  logic                 unused_ld_lane;

  store_aligner u_aligner (
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .store_word (StoreWord),
    .wdata      (al_wdata),
    .be         (al_be),
    .illegal    (al_illegal)
  );

  assign st_ready = (count != CNT_FULL);
  assign empty    = (count == '0);
  assign mem_req  = !empty;
  assign accept   = st_valid && st_ready;
  assign push     = accept && !al_illegal;
  assign pop      = mem_req && mem_ack;

  assign head      = fifo[rd_ptr];
  assign mem_addr  = {head.waddr, 2'b00};
  assign mem_wdata = head.wdata;
  assign mem_be    = head.be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
      misaligned  <= 1'b0;
    end else begin
      misaligned <= accept && al_illegal;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // wr_ptr never equals rd_ptr on a simultaneous push/pop unless empty,
      // and pop requires non-empty, so these never collide on one bit.
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && rd_ptr == PTR_W'(i)) begin
          entry_valid[i] <= 1'b0;
        end
        if (push && wr_ptr == PTR_W'(i)) begin
          entry_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset: entry_valid and count qualify every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= '{waddr: st_addr[ADDR_BITS-1:2], wdata: al_wdata, be: al_be};
    end
  end

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && fifo[i].waddr == ld_addr[ADDR_BITS-1:2]) begin
        ld_conflict = 1'b1;
      end
    end
  end

  assign unused_ld_lane = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: alignment, drops, full/drain ordering,
// streaming wrap, load conflict and asynchronous reset.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  StoreWord;
  logic        misaligned;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  store_write_buffer #(.DATA_BITS(32), .ADDR_BITS(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .StoreWord   (StoreWord),
    .misaligned  (misaligned),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .ld_addr     (ld_addr),
    .ld_conflict (ld_conflict),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    StoreWord = sz;
  endtask

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    StoreWord = 2'd0;
    mem_ack   = 1'b0;
    ld_addr   = 32'hFFFF_FFF0;
    #2;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // SB 0x1003 with immediate ack
    drive_st(32'h1003, 32'h0000_00AB, 2'd1);
    mem_ack = 1'b1;
    tick();
    st_valid = 1'b0;
    chk("sb_req", {31'b0, mem_req}, 32'd1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", {28'b0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    tick();
    mem_ack = 1'b0;
    chk("sb_empty_after", {31'b0, empty}, 32'd1);
    chk("sb_req_after", {31'b0, mem_req}, 32'd0);

    // SH upper half
    drive_st(32'h2002, 32'h1234_CDEF, 2'd2);
    tick();
    st_valid = 1'b0;
    chk("sh_be", {28'b0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hCDEF_CDEF);
    chk("sh_addr", mem_addr, 32'h2000);
    chk("sh_no_misal", {31'b0, misaligned}, 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sh_drained", {31'b0, empty}, 32'd1);

    // misaligned SH and undefined width are dropped with a one-cycle pulse
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive_st(32'h2001, 32'h5555_5555, 2'd2);
      else        drive_st(32'h2000, 32'h6666_6666, 2'd3);
      chk("drop_ready", {31'b0, st_ready}, 32'd1);
      tick();
      st_valid = 1'b0;
      chk("drop_pulse", {31'b0, misaligned}, 32'd1);
      chk("drop_no_req", {31'b0, mem_req}, 32'd0);
      tick();
      chk("drop_pulse_end", {31'b0, misaligned}, 32'd0);
      chk("drop_still_empty", {31'b0, empty}, 32'd1);
    end

    // fill to DEPTH without ack, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive_st(32'h10 + 32'(4 * i), 32'hC000_0000 + 32'(i), 2'd0);
      chk("fill_ready", {31'b0, st_ready}, 32'd1);
      tick();
    end
    st_valid = 1'b0;
    chk("full_not_ready", {31'b0, st_ready}, 32'd0);
    drive_st(32'h20, 32'hDEAD_BEEF, 2'd0);
    tick();
    st_valid = 1'b0;
    chk("full_5th_blocked", {31'b0, st_ready}, 32'd0);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_req", {31'b0, mem_req}, 32'd1);
      chk("drain_addr", mem_addr, 32'h10 + 32'(4 * i));
      chk("drain_data", mem_wdata, 32'hC000_0000 + 32'(i));
      tick();
      if (i == 0) chk("ready_after_pop", {31'b0, st_ready}, 32'd1);
    end
    chk("drain_done_empty", {31'b0, empty}, 32'd1);
    chk("drain_done_req", {31'b0, mem_req}, 32'd0);

    // steady stream with ack every cycle, pointers wrap
    for (int i = 0; i < 10; i++) begin
      drive_st(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd0);
      tick();
      chk("stream_addr", mem_addr, 32'h100 + 32'(4 * i));
      chk("stream_data", mem_wdata, 32'hA000_0000 + 32'(i));
      chk("stream_ready", {31'b0, st_ready}, 32'd1);
    end
    st_valid = 1'b0;
    tick();
    mem_ack = 1'b0;
    chk("stream_empty", {31'b0, empty}, 32'd1);

    // load conflict
    drive_st(32'h3000, 32'h0BAD_F00D, 2'd0);
    ld_addr = 32'h3000;
    #1;
    chk("ldc_excl_accepting", {31'b0, ld_conflict}, 32'd0);
    tick();
    st_valid = 1'b0;
    ld_addr = 32'h3002;
    #1;
    chk("ldc_hit", {31'b0, ld_conflict}, 32'd1);
    ld_addr = 32'h3004;
    #1;
    chk("ldc_other_word", {31'b0, ld_conflict}, 32'd0);
    ld_addr = 32'h3002;
    mem_ack = 1'b1;
    #1;
    chk("ldc_ack_cycle", {31'b0, ld_conflict}, 32'd1);
    tick();
    mem_ack = 1'b0;
    chk("ldc_after_ack", {31'b0, ld_conflict}, 32'd0);
    ld_addr = 32'hFFFF_FFF0;

    // asynchronous reset with 3 entries pending
    for (int i = 0; i < 3; i++) begin
      drive_st(32'h40 + 32'(4 * i), 32'hE000_0000 + 32'(i), 2'd0);
      tick();
    end
    st_valid = 1'b0;
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, mem_req}, 32'd0);
    chk("arst_empty", {31'b0, empty}, 32'd1);
    chk("arst_ready", {31'b0, st_ready}, 32'd1);
    #10 rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_stale", {31'b0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Store-side counterpart of the register writeback load-extraction path.
- Takes store requests from the MEM stage: register data, byte address, width.
- Aligns data into byte lanes and generates byte enables.
- Queues entries in a small FIFO and drains them to data memory over a req/ack handshake, flagging loads that hit a pending store.

Parameters:
- DATA_BITS, 32, data word width (fixed at 32; byte-lane logic assumes 4 lanes)
- ADDR_BITS, 32, byte address width
- DEPTH, 4, FIFO entries (power of 2, >= 2)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- st_valid  input  1  store request valid
- st_ready  output  1  buffer can accept a store
- st_addr  input  ADDR_BITS  byte address of store
- st_data  input  DATA_BITS  register (rt) value, right-justified
- StoreWord  input  2  store width: 0 word, 1 byte, 2 halfword, 3 undefined
- misaligned  output  1  one-cycle pulse: accepted request was misaligned or undefined, and was dropped
- mem_req  output  1  head entry valid, write requested
- mem_ack  input  1  memory accepted head write this cycle
- mem_addr  output  ADDR_BITS  word-aligned address, low 2 bits 0
- mem_wdata  output  DATA_BITS  lane-aligned write data
- mem_be  output  4  byte enables, bit i = byte lane [8i+7:8i]
- ld_addr  input  ADDR_BITS  byte address of load in MEM stage
- ld_conflict  output  1  combinational: a buffered entry matches ld_addr word
- empty  output  1  no entries pending (used for fence/syscall drain)

Behaviour:
- Reset (async, rst_n low): rd/wr pointers 0, count 0, misaligned 0. mem_req 0, empty 1, st_ready 1. Pending entries are discarded, including one mid-handshake.
- Accept when st_valid && st_ready.
  - st_ready = (count != DEPTH), independent of a same-cycle pop.
- Alignment, a = st_addr[1:0]:
  - Word: legal iff a==0. be=1111, wdata=st_data.
  - Byte: always legal. be = 0001 << a, wdata = {4{st_data[7:0]}}.
  - Half: legal iff a[0]==0. be = a[1] ? 1100 : 0011, wdata = {2{st_data[15:0]}}.
  - StoreWord==3: illegal.
- Illegal accepted request:
  - Nothing is pushed.
  - misaligned pulses high the following cycle for exactly 1 cycle.
  - st_ready is not affected.
- Legal accepted request:
  - Pushes {addr with [1:0] cleared, wdata, be} at wr_ptr.
  - wr_ptr wraps modulo DEPTH; count increments.
- Drain:
  - mem_req = !empty; mem_addr/mem_wdata/mem_be come from the head entry.
  - They are stable while mem_req && !mem_ack.
  - Pop on mem_req && mem_ack: rd_ptr wraps modulo DEPTH, count decrements.
  - mem_ack while mem_req low is ignored.
- Latency: a store accepted in cycle N (empty buffer) gives mem_req=1 in N+1. Minimum occupancy is 1 cycle with an immediate ack.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal when count==DEPTH? No: st_ready is already 0, so no push.
- Full: st_ready=0 until a pop completes; st_ready rises the cycle after the pop.
- Empty: mem_req=0; mem_addr/wdata/be hold the last head value (don't-care).
- ld_conflict:
  - Compares ld_addr[ADDR_BITS-1:2] against every valid entry's word address.
  - Excludes the entry being accepted in the same cycle.
  - The head entry counts as valid until the cycle after its ack.
- empty = (count==0), registered-equivalent (derived from count).

Decomposition:
- Shared package mem_access_pkg:
  - StoreWord/ExtrWord width encodings: SZ_WORD=0, SZ_BYTE=1, SZ_HALF=2, SZ_UNDEF=3.
  - Byte-enable constants BE_ALL=4'b1111, BE_LO=4'b0011, BE_HI=4'b1100.
  - The FIFO entry typedef.
- Combinational sub-module store_aligner: (addr, data, StoreWord) -> (wdata, be, illegal).
- The top holds the FIFO, pointers, counter, handshake and conflict compare.

Test Plan:
- SB to 0x1003 with data 0x000000AB, mem_ack=1 -> next cycle mem_req=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB; empty=1 after the ack cycle.
- SH to 0x2002 with data 0x1234CDEF -> mem_be=1100, wdata=0xCDEFCDEF. SH to 0x2001 -> no mem_req, misaligned=1 for exactly one cycle. StoreWord=3 to 0x2000 -> same drop and pulse.
- mem_ack=0, push 4 SW (0x10,0x14,0x18,0x1C) -> st_ready=0 after the 4th. A 5th request is not accepted. Hold mem_ack=1 -> drain in order 0x10..0x1C, one per cycle; st_ready=1 the cycle after the first pop.
- Steady stream of SW with mem_ack=1 every cycle -> count stays 1, pointers wrap past DEPTH-1 to 0 without data corruption (check 10 sequential values).
- Buffered SW 0x3000 pending, ld_addr=0x3002 -> ld_conflict=1. ld_addr=0x3004 -> 0. After the ack, the next cycle ld_addr=0x3002 -> 0.
- Buffer holding 3 entries, mem_req high, deassert rst_n mid-cycle -> mem_req=0, empty=1, st_ready=1 immediately (asynchronous). After release, no stale entries drain.
